// File: rtl/mux_n_1_rr_reg.sv
// N-to-1 round-robin merge of valid/ready channels onto one output register; optional out_ch via MUX_N_1_CH_ID_EN.
// Latency: a word accepted in cycle t appears on Output in t+1; one word per cycle sustained.
// Backpressure: out_valid & !out_ready freezes the register and drops every in_ready.
module mux_n_1_rr_reg #(
  parameter int NBits = 32,
  parameter int NCh   = 4,
  localparam int IdxW = (NCh > 1) ? $clog2(NCh) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCh*NBits-1:0] In,
  input  logic [NCh-1:0]       in_valid,
  output logic [NCh-1:0]       in_ready,
  output logic [NBits-1:0]     Output,
  output logic                 out_valid,
`ifdef MUX_N_1_CH_ID_EN
  input  logic                 out_ready,
  output logic [IdxW-1:0]      out_ch
`else
  input  logic                 out_ready
`endif
);

  logic [IdxW-1:0]  rr_ptr;
  logic [IdxW-1:0]  grant_idx;
  logic [IdxW:0]    cand;
  logic             found;
  logic             load_en;
  logic             any_valid;
  logic [NBits-1:0] grant_dat;

  assign load_en   = !out_valid || out_ready;
  assign any_valid = |in_valid;

  // Scan channels starting at rr_ptr; the wrap is an explicit subtract so non-power-of-2 NCh stays exact.
  always_comb begin
    grant_idx = rr_ptr;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NCh; i++) begin
      cand = {1'b0, rr_ptr} + (IdxW+1)'(i);
      if (cand >= (IdxW+1)'(NCh)) begin
        cand = cand - (IdxW+1)'(NCh);
      end
      if (!found && in_valid[cand[IdxW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IdxW-1:0];
      end
    end
  end

  assign grant_dat = In[int'(grant_idx)*NBits +: NBits];

  always_comb begin
    in_ready = '0;
    if (load_en && any_valid && !reset) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Output    <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      if (any_valid) begin
        Output    <= grant_dat;
        out_valid <= 1'b1;
        rr_ptr    <= (grant_idx == IdxW'(NCh-1)) ? '0 : grant_idx + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_N_1_CH_ID_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      out_ch <= '0;
    end else if (load_en && any_valid) begin
      out_ch <= grant_idx;
    end
  end
`endif

  a_ready_onehot: assert property (@(posedge clk) $onehot0(in_ready));

endmodule
